// File: rtl/scaler_pixel_engine.sv
// Frame scaler: walks the target raster, accumulates fixed-point source coordinates,
// fetches neighbour pixels from a source memory and emits nearest or bilinear pixels.
module scaler_pixel_engine #(
  parameter int PIX_W  = 16,
  parameter int DIM_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [DIM_W-1:0]        sw,
  input  logic [DIM_W-1:0]        sh,
  input  logic [DIM_W-1:0]        tw,
  input  logic [DIM_W-1:0]        th,
  input  logic [DIM_W+FRAC_W-1:0] step_x,
  input  logic [DIM_W+FRAC_W-1:0] step_y,
  output logic                    mem_rd,
  output logic [DIM_W-1:0]        mem_x,
  output logic [DIM_W-1:0]        mem_y,
  input  logic [PIX_W-1:0]        mem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PIX_W-1:0]        out_pixel,
  output logic [DIM_W-1:0]        out_x,
  output logic [DIM_W-1:0]        out_y,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              dbg_state
);

  localparam int ACC_W = DIM_W + FRAC_W;
  localparam int CW    = PIX_W + 2*FRAC_W + 1;
  localparam logic [ACC_W:0]    HALF  = (ACC_W+1)'(1) << (FRAC_W-1);
  localparam logic [FRAC_W:0]   W_ONE = (FRAC_W+1)'(1) << FRAC_W;
  localparam logic [CW-1:0]     RND   = CW'(1) << (2*FRAC_W-1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_CALC  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic                mode_q;
  logic [DIM_W-1:0]    sw_q, sh_q, tw_q, th_q;
  logic [ACC_W-1:0]    stx_q, sty_q;
  logic [DIM_W-1:0]    tx, ty;
  logic [ACC_W-1:0]    acc_x, acc_y;
  logic [1:0]          fc;
  logic                rd_q;
  logic [1:0]          rd_idx_q;
  logic [PIX_W-1:0]    p00, p10, p01, p11;
  logic [PIX_W-1:0]    pix_q;

  // ---------------- source coordinate generation ----------------
  logic [DIM_W-1:0]  ix, iy, xmax, ymax;
  logic [FRAC_W-1:0] fx, fy;
  logic [DIM_W:0]    ix1, iy1;
  logic [DIM_W-1:0]  x0, x1, y0, y1, nx, ny;
  logic [ACC_W:0]    rnd_x, rnd_y;
  logic [DIM_W:0]    nx_raw, ny_raw;

  always_comb begin
    ix     = acc_x[ACC_W-1:FRAC_W];
    iy     = acc_y[ACC_W-1:FRAC_W];
    fx     = acc_x[FRAC_W-1:0];
    fy     = acc_y[FRAC_W-1:0];
    xmax   = sw_q - DIM_W'(1);
    ymax   = sh_q - DIM_W'(1);
    ix1    = {1'b0, ix} + (DIM_W+1)'(1);
    iy1    = {1'b0, iy} + (DIM_W+1)'(1);
    x0     = (ix > xmax) ? xmax : ix;
    y0     = (iy > ymax) ? ymax : iy;
    x1     = (ix1 > {1'b0, xmax}) ? xmax : ix1[DIM_W-1:0];
    y1     = (iy1 > {1'b0, ymax}) ? ymax : iy1[DIM_W-1:0];
    // Nearest rounds half up before clamping to the last column/row.
    rnd_x  = {1'b0, acc_x} + HALF;
    rnd_y  = {1'b0, acc_y} + HALF;
    nx_raw = rnd_x[ACC_W:FRAC_W];
    ny_raw = rnd_y[ACC_W:FRAC_W];
    nx     = (nx_raw > {1'b0, xmax}) ? xmax : nx_raw[DIM_W-1:0];
    ny     = (ny_raw > {1'b0, ymax}) ? ymax : ny_raw[DIM_W-1:0];
  end

  // Bilinear fetch order: fc bit 0 picks x1, bit 1 picks y1.
  always_comb begin
    mem_rd = (state == S_FETCH);
    mem_x  = '0;
    mem_y  = '0;
    if (mem_rd) begin
      mem_x = mode_q ? (fc[0] ? x1 : x0) : nx;
      mem_y = mode_q ? (fc[1] ? y1 : y0) : ny;
    end
  end

  // ---------------- bilinear blend ----------------
  logic [FRAC_W:0]  wfx, wfy;
  logic [CW-1:0]    top, bot, blend;
  logic [PIX_W-1:0] bil_pix;
  logic             unused_bits;

  always_comb begin
    wfx     = W_ONE - {1'b0, fx};
    wfy     = W_ONE - {1'b0, fy};
    top     = CW'(p00) * CW'(wfx) + CW'(p10) * CW'(fx);
    bot     = CW'(p01) * CW'(wfx) + CW'(p11) * CW'(fx);
    blend   = top * CW'(wfy) + bot * CW'(fy) + RND;
    bil_pix = blend[2*FRAC_W +: PIX_W];
  end

  assign unused_bits = ^{blend[CW-1], blend[2*FRAC_W-1:0],
                         rnd_x[FRAC_W-1:0], rnd_y[FRAC_W-1:0]};

  // ---------------- control ----------------
  logic dims_zero, last_x, last_pix;

  assign dims_zero = (sw == '0) || (sh == '0) || (tw == '0) || (th == '0);
  assign last_x    = (tx == tw_q - DIM_W'(1));
  assign last_pix  = last_x && (ty == th_q - DIM_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = dims_zero ? S_DONE : S_FETCH;
      S_FETCH: if (!mode_q || fc == 2'd3) state_nx = S_WAIT;
      S_WAIT:  state_nx = S_CALC;
      S_CALC:  state_nx = S_OUT;
      S_OUT:   if (out_ready) state_nx = last_pix ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake: out_valid rises in OUT and holds out_pixel/out_x/out_y stable until a
  // cycle with out_ready=1; that cycle transfers the pixel and out_valid drops next cycle.
  assign out_valid = (state == S_OUT);
  assign out_pixel = pix_q;
  assign out_x     = tx;
  assign out_y     = ty;
  assign busy      = (state == S_FETCH) || (state == S_WAIT) ||
                     (state == S_CALC)  || (state == S_OUT);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= 1'b0;
      sw_q     <= '0;
      sh_q     <= '0;
      tw_q     <= '0;
      th_q     <= '0;
      stx_q    <= '0;
      sty_q    <= '0;
      tx       <= '0;
      ty       <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
      fc       <= '0;
      rd_q     <= 1'b0;
      rd_idx_q <= '0;
      p00      <= '0;
      p10      <= '0;
      p01      <= '0;
      p11      <= '0;
      pix_q    <= '0;
    end else begin
      rd_q     <= mem_rd;
      rd_idx_q <= fc;
      if (rd_q) begin
        case (rd_idx_q)
          2'd0: p00 <= mem_rdata;
          2'd1: p10 <= mem_rdata;
          2'd2: p01 <= mem_rdata;
          2'd3: p11 <= mem_rdata;
        endcase
      end
      case (state)
        S_IDLE: if (start) begin
          mode_q <= mode;
          sw_q   <= sw;
          sh_q   <= sh;
          tw_q   <= tw;
          th_q   <= th;
          stx_q  <= step_x;
          sty_q  <= step_y;
          tx     <= '0;
          ty     <= '0;
          acc_x  <= '0;
          acc_y  <= '0;
          fc     <= '0;
        end
        S_FETCH: fc <= (mode_q && fc != 2'd3) ? fc + 2'd1 : 2'd0;
        S_CALC:  pix_q <= mode_q ? bil_pix : p00;
        S_OUT: if (out_ready && !last_pix) begin
          // A single-column or single-row target never adds its step, so the source stays 0.
          if (last_x) begin
            tx    <= '0;
            acc_x <= '0;
            ty    <= ty + DIM_W'(1);
            acc_y <= acc_y + sty_q;
          end else begin
            tx    <= tx + DIM_W'(1);
            acc_x <= acc_x + stx_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scaler_pixel_engine.sv
// Directed bench for scaler_pixel_engine: hand-computed pixels go into an expected
// queue and a negedge monitor pops and compares them on every output handshake.
module tb_scaler_pixel_engine;

  localparam int PIX_W  = 16;
  localparam int DIM_W  = 16;
  localparam int FRAC_W = 8;
  localparam int W      = PIX_W + 2*DIM_W;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic                    mode;
  logic [DIM_W-1:0]        sw, sh, tw, th;
  logic [DIM_W+FRAC_W-1:0] step_x, step_y;
  logic                    mem_rd;
  logic [DIM_W-1:0]        mem_x, mem_y;
  logic [PIX_W-1:0]        mem_rdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [PIX_W-1:0]        out_pixel;
  logic [DIM_W-1:0]        out_x, out_y;
  logic                    busy, done;
  logic [2:0]              dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [PIX_W-1:0] mem [0:63];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  scaler_pixel_engine #(.PIX_W(PIX_W), .DIM_W(DIM_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .sw(sw), .sh(sh), .tw(tw), .th(th), .step_x(step_x), .step_y(step_y),
    .mem_rd(mem_rd), .mem_x(mem_x), .mem_y(mem_y), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_x(out_x), .out_y(out_y), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Source memory: one-cycle read latency, row pitch of 8.
  always @(posedge clk) mem_rdata <= mem_rd ? mem[{mem_y[2:0], mem_x[2:0]}] : '0;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int p, input int x, input int y);
    exp_q.push_back({PIX_W'(p), DIM_W'(x), DIM_W'(y)});
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pixel_extra: got p=%0d x=%0d y=%0d want none", out_pixel, out_x, out_y);
      end else begin
        e = exp_q.pop_front();
        check("pixel", 64'({out_pixel, out_x, out_y}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  task automatic load_identity();
    clear_mem();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) mem[y*8+x] = PIX_W'(16*y + x);
  endtask

  task automatic push_identity();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) push_exp(16*y + x, x, y);
  endtask

  task automatic run_frame(input logic m, input int s_w, input int s_h, input int t_w,
                           input int t_h, input int st_x, input int st_y, input int restart_at,
                           output int lat, output int reads, output int outs,
                           output int oob, output int done_at);
    int first_rd, first_ov;
    first_rd = -1; first_ov = -1; lat = -1;
    reads = 0; outs = 0; oob = 0; done_at = -1;
    @(posedge clk); #1;
    mode = m; sw = DIM_W'(s_w); sh = DIM_W'(s_h); tw = DIM_W'(t_w); th = DIM_W'(t_h);
    step_x = (DIM_W+FRAC_W)'(st_x); step_y = (DIM_W+FRAC_W)'(st_y);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (mem_rd) begin
        reads++;
        if (first_rd < 0) first_rd = i;
        if (mem_x >= sw || mem_y >= sh) oob++;
      end
      if (out_valid && first_ov < 0) first_ov = i;
      if (out_valid && out_ready) outs++;
      if (done) begin
        done_at = i;
        check("busy_at_done", 64'(busy), 64'(0));
        break;
      end
      @(posedge clk); #1;
      start = (i == restart_at);
    end
    start = 1'b0;
    if (done_at < 0) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: got no done want done within 800 cycles");
    end else begin
      @(negedge clk);
      check("done_pulse_width", 64'(done), 64'(0));
    end
    if (first_rd >= 0 && first_ov >= 0) lat = first_ov - first_rd;
  endtask

  // Holds out_ready low once pixel (0,0) is taken, then watches pixel (1,0) stall.
  task automatic stall_check();
    int n;
    logic [W-1:0] held;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready && out_x == 0 && out_y == 0) && n < 300);
    @(posedge clk); #1;
    out_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check("stall_x", 64'(out_x), 64'(1));
    check("stall_y", 64'(out_y), 64'(0));
    check("stall_pix", 64'(out_pixel), 64'(50));
    held = {out_pixel, out_x, out_y};
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_hold", 64'({out_pixel, out_x, out_y}), 64'(held));
      check("stall_no_rd", 64'(mem_rd), 64'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, reads, outs, oob, done_at, n;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    sw = '0; sh = '0; tw = '0; th = '0; step_x = '0; step_y = '0;
    out_ready = 1'b1;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({mem_rd, out_valid, busy, done}), 64'(0));
    check("reset_mem_xy", 64'({mem_x, mem_y}), 64'(0));
    check("reset_out_data", 64'({out_pixel, out_x, out_y}), 64'(0));
    reset = 1'b0;

    // Identity 4x4 -> 4x4
    load_identity();
    push_identity();
    run_frame(1'b1, 4, 4, 4, 4, 256, 256, 0, lat, reads, outs, oob, done_at);
    check("ident_reads", 64'(reads), 64'(64));
    check("ident_outs", 64'(outs), 64'(16));
    check("ident_latency", 64'(lat), 64'(6));
    check("ident_queue_left", 64'(exp_q.size()), 64'(0));

    // Upscale 2x2 -> 3x3 with backpressure on pixel (1,0)
    clear_mem();
    mem[0] = 16'd0; mem[1] = 16'd100; mem[8] = 16'd200; mem[9] = 16'd300;
    push_exp(0, 0, 0);   push_exp(50, 1, 0);  push_exp(100, 2, 0);
    push_exp(100, 0, 1); push_exp(150, 1, 1); push_exp(200, 2, 1);
    push_exp(200, 0, 2); push_exp(250, 1, 2); push_exp(300, 2, 2);
    fork
      run_frame(1'b1, 2, 2, 3, 3, 128, 128, 0, lat, reads, outs, oob, done_at);
      stall_check();
    join
    check("up_reads", 64'(reads), 64'(36));
    check("up_outs", 64'(outs), 64'(9));
    check("up_clamped_reads", 64'(oob), 64'(0));
    check("up_queue_left", 64'(exp_q.size()), 64'(0));

    // Nearest 2x2 -> 4x4, with a stray start pulse mid-frame
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) push_exp(((y >= 2) ? 200 : 0) + ((x >= 2) ? 100 : 0), x, y);
    run_frame(1'b0, 2, 2, 4, 4, 64, 64, 10, lat, reads, outs, oob, done_at);
    check("near_reads", 64'(reads), 64'(16));
    check("near_outs", 64'(outs), 64'(16));
    check("near_latency", 64'(lat), 64'(3));
    check("near_oob", 64'(oob), 64'(0));
    check("near_queue_left", 64'(exp_q.size()), 64'(0));

    // Degenerate tw=0
    run_frame(1'b1, 4, 4, 0, 4, 256, 256, 0, lat, reads, outs, oob, done_at);
    check("degen_done_at", 64'(done_at), 64'(1));
    check("degen_reads", 64'(reads), 64'(0));
    check("degen_outs", 64'(outs), 64'(0));

    // Reset during the third fetch read, then a clean identity frame
    load_identity();
    @(posedge clk); #1;
    mode = 1'b1; sw = 16'd4; sh = 16'd4; tw = 16'd4; th = 16'd4;
    step_x = 24'd256; step_y = 24'd256; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    reads = 0;
    while (reads < 3 && n < 50) begin
      @(negedge clk);
      n++;
      if (mem_rd) reads++;
    end
    check("midreset_saw_reads", 64'(reads), 64'(3));
    #2 reset = 1'b1;
    #1;
    check("midreset_ctrl", 64'({mem_rd, out_valid, busy, done}), 64'(0));
    check("midreset_mem_xy", 64'({mem_x, mem_y}), 64'(0));
    check("midreset_out_data", 64'({out_pixel, out_x, out_y}), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    push_identity();
    run_frame(1'b1, 4, 4, 4, 4, 256, 256, 0, lat, reads, outs, oob, done_at);
    check("rerun_reads", 64'(reads), 64'(64));
    check("rerun_outs", 64'(outs), 64'(16));
    check("rerun_latency", 64'(lat), 64'(6));
    check("rerun_queue_left", 64'(exp_q.size()), 64'(0));

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scaler_pixel_engine.md
Name: scaler_pixel_engine

Overview:
- Parametrised frame-level bilinear/nearest-neighbour scaling engine.
- Walks the target raster and generates fixed-point source coordinates by DDA accumulation.
- Fetches the neighbour pixels from a source-image memory port and emits one scaled pixel per handshake.
- Successor to the fixed 16-bit single-mode top_processor datapath; it owns address generation itself instead of relying on an external neighbour fetch.

Parameters:
PIX_W, 16, pixel width in bits
DIM_W, 16, width of image dimensions and integer coordinates
FRAC_W, 8, fractional bits of step and coordinate accumulators

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse, begins a frame; ignored while busy
mode  in  1  0 = nearest neighbour, 1 = bilinear
sw, sh  in  DIM_W  source width/height
tw, th  in  DIM_W  target width/height
step_x, step_y  in  DIM_W+FRAC_W  unsigned source increment per target pixel (software computes (s-1)/(t-1))
mem_rd  out  1  read strobe
mem_x, mem_y  out  DIM_W  source read coordinate
mem_rdata  in  PIX_W  read data, valid exactly 1 cycle after mem_rd
out_valid  out  1  out_pixel valid
out_ready  in  1  consumer accepts
out_pixel  out  PIX_W  scaled pixel
out_x, out_y  out  DIM_W  target coordinate of out_pixel
busy  out  1  frame in progress
done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE and accumulators clear, even mid-frame. No pending read completes.
- start in IDLE: latch mode, sw, sh, tw, th, step_x, step_y; busy=1. If any dimension is 0, pulse done next cycle with no reads and no outputs, then return to IDLE.
- States: IDLE -> FETCH -> WAIT -> CALC -> OUT -> (FETCH | DONE) -> IDLE.
- Coordinates: src_x = tx*step_x and src_y = ty*step_y, accumulated, never multiplied. ix = src_x>>FRAC_W, fx = low FRAC_W bits; same for y.
- Bilinear FETCH: 4 consecutive mem_rd cycles in the order (x0,y0), (x1,y0), (x0,y1), (x1,y1).
  - x0 = min(ix, sw-1); x1 = min(ix+1, sw-1); y likewise with sh.
  - Clamping applies at the right and bottom edges.
- Nearest FETCH: one read at min((src+2^(FRAC_W-1))>>FRAC_W, dim-1) per axis (round half up).
- WAIT: one cycle to capture the last mem_rdata.
- CALC, bilinear, with W = 2^FRAC_W:
  - top = p00*(W-fx) + p10*fx
  - bot = p01*(W-fx) + p11*fx
  - out = (top*(W-fy) + bot*fy + 2^(2*FRAC_W-1)) >> (2*FRAC_W)
  - Intermediates are PIX_W+2*FRAC_W+1 bits, so no overflow occurs.
  - Nearest mode passes the single read through unchanged.
- Latency from FETCH entry to out_valid: 6 cycles in bilinear mode, 3 in nearest mode.
- OUT: out_valid held with out_pixel, out_x, out_y stable until out_ready. No mem_rd is issued while stalled.
  - The handshake cycle advances tx. At tx = tw-1, tx wraps to 0, src_x clears, and ty/src_y advance.
  - out_valid may not reassert in the same cycle as the handshake.
- Raster order: x fastest, origin (0,0).
- tw=1 or th=1: step on that axis is ignored; source coordinate stays 0.
- DONE: done=1 for one cycle after the final handshake; busy falls in the same cycle.
- A start pulse coincident with done is ignored.

Test Plan:
- Identity: 4x4 -> 4x4, step=256, bilinear, mem[y][x]=16*y+x -> 16 outputs equal to source in raster order, then done pulse; 4 reads per pixel.
- Upscale: 2x2 [0,100;200,300] -> 3x3, step=128, bilinear -> rows {0,50,100}, {100,150,200}, {200,250,300}; pixel (2,2) reads are clamped to (1,1).
- Nearest: 2x2 row0 [0,100] -> 4x4, step=64, mode=0 -> row0 = 0,0,100,100; exactly one mem_rd per output; out_valid 3 cycles after FETCH entry.
- Backpressure: out_ready low for 5 cycles at pixel (1,0) -> out_valid stays 1, out_pixel/out_x/out_y stable, mem_rd=0 throughout; pixel (2,0) follows after release.
- Reset mid-frame: assert reset during the third FETCH read -> all outputs 0 immediately (asynchronously); a new start afterwards reproduces the identity test exactly.
- Degenerate: tw=0 -> done one cycle after start, zero mem_rd, zero out_valid. A start pulse while busy is ignored (output count unchanged).
